preg_alloc_sched: RTL

PREG_ALLOC_SCHED -- requirements
Module: preg_alloc_sched

---
 rtl/preg_alloc_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/preg_alloc_sched.sv
// Physical-register allocation scheduler.
// Front-end for a multi-lane free-list FIFO: resets the FIFO, drains the tags
// that back architectural state (0..ARCH_REGS-1), then grants rename groups
// all-or-nothing and returns committed tags to the FIFO.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   alloc_valid/req      rename group and per-lane destination requests
//   alloc_ready/tag      group accepted this cycle; granted tag per lane
//   free_en/free_tag     commit lanes returning tags
//   fl_rst               active-high FIFO reset
//   fl_get_en/gotten     FIFO get enables / data
//   fl_put_en/put        FIFO put enables / data
//   fl_len               FIFO occupancy
//   init_done            block is in RUN
//   err_overfree         sticky over-free error
//   stall_cycles         RUN cycles with a group waiting but not accepted
//   grant_total          tags granted (wrapping)
//
// Optional feature macro: PREG_ALLOC_STATS_EN enables the statistics counters;
// when undefined stall_cycles and grant_total are tied to zero.
module preg_alloc_sched #(
  parameter int NUM_PREGS = 64,
  parameter int TAG_W     = 6,
  parameter int WIDTH     = 3,
  parameter int ARCH_REGS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  input  logic [WIDTH-1:0]              alloc_req,
  output logic                          alloc_ready,
  output logic [WIDTH-1:0][TAG_W-1:0]   alloc_tag,
  input  logic [WIDTH-1:0]              free_en,
  input  logic [WIDTH-1:0][TAG_W-1:0]   free_tag,
  output logic                          fl_rst,
  output logic [WIDTH-1:0]              fl_get_en,
  input  logic [WIDTH-1:0][TAG_W-1:0]   fl_gotten,
  output logic [WIDTH-1:0]              fl_put_en,
  output logic [WIDTH-1:0][TAG_W-1:0]   fl_put,
  input  logic [TAG_W:0]                fl_len,
  output logic                          init_done,
  output logic                          err_overfree,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   grant_total
);

  // The FIFO can never give up more tags than it holds.
  localparam int DrainTotal = (ARCH_REGS < NUM_PREGS) ? ARCH_REGS : NUM_PREGS;
  localparam logic [TAG_W:0] DrainTotalW = (TAG_W+1)'(DrainTotal);
  localparam logic [TAG_W:0] WidthW      = (TAG_W+1)'(WIDTH);

  typedef enum logic [1:0] {StHold, StDrain, StRun} state_e;

  function automatic logic [TAG_W:0] popcnt(input logic [WIDTH-1:0] v);
    logic [TAG_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + {{TAG_W{1'b0}}, v[i]};
    return c;
  endfunction

  state_e         state_q;
  logic [TAG_W:0] drain_cnt_q;
  logic [TAG_W:0] alloc_cnt_q;
  logic           fl_rst_q;
  logic           init_done_q;
  logic           err_q;

  logic [TAG_W:0]   drain_left;
  logic [TAG_W:0]   drain_k;
  logic             drain_done;
  logic             is_run;
  logic [TAG_W:0]   n_req;
  logic             grant;
  logic [TAG_W:0]   n_granted;
  logic [TAG_W:0]   m_free;
  logic [TAG_W+1:0] alloc_sum;
  logic             free_ok;
  logic [TAG_W:0]   alloc_cnt_d;
  logic             over_free;

  always_comb begin
    drain_left  = DrainTotalW - drain_cnt_q;
    drain_k     = (drain_left < WidthW) ? drain_left : WidthW;
    drain_done  = (drain_cnt_q + drain_k) == DrainTotalW;
    is_run      = (state_q == StRun);
    n_req       = alloc_valid ? popcnt(alloc_req) : '0;
    // fl_len is only consulted in RUN; is_run masks it elsewhere.
    alloc_ready = is_run && (n_req <= fl_len);
    grant       = alloc_ready && alloc_valid;
    n_granted   = grant ? n_req : '0;
    m_free      = popcnt(free_en);
    // Tags granted this same cycle may already be freed back.
    alloc_sum   = {1'b0, alloc_cnt_q} + {1'b0, n_granted};
    free_ok     = is_run && ({1'b0, m_free} <= alloc_sum);
    alloc_cnt_d = free_ok ? (TAG_W+1)'(alloc_sum - {1'b0, m_free}) : (TAG_W+1)'(alloc_sum);
    over_free   = (|free_en) && !free_ok;

    for (int i = 0; i < WIDTH; i++) begin
      if (state_q == StDrain) begin
        fl_get_en[i] = (TAG_W+1)'(i) < drain_k;
      end else begin
        fl_get_en[i] = grant && alloc_req[i];
      end
      alloc_tag[i] = (grant && alloc_req[i]) ? fl_gotten[i] : '0;
      fl_put_en[i] = free_ok && free_en[i];
      fl_put[i]    = fl_put_en[i] ? free_tag[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StHold;
      fl_rst_q    <= 1'b1;
      init_done_q <= 1'b0;
      drain_cnt_q <= '0;
      alloc_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          state_q  <= StDrain;
          fl_rst_q <= 1'b0;
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_q + drain_k;
          if (drain_done) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: alloc_cnt_q <= alloc_cnt_d;
        default: begin
          state_q  <= StHold;
          fl_rst_q <= 1'b1;
        end
      endcase
      if (over_free) err_q <= 1'b1;
    end
  end

  assign fl_rst       = fl_rst_q;
  assign init_done    = init_done_q;
  assign err_overfree = err_q;

`ifdef PREG_ALLOC_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] grant_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      grant_q <= '0;
    end else begin
      if (is_run && alloc_valid && !alloc_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      grant_q <= grant_q + 32'(n_granted);
    end
  end

  assign stall_cycles = stall_q;
  assign grant_total  = grant_q;
`else
  assign stall_cycles = '0;
  assign grant_total  = '0;
`endif

endmodule
